aes_inv_sub_bytes: RTL and testbench

Iterative AES InvSubBytes engine: accepts a 128-bit cipher state over a valid/ready handshake and applies the inverse S-box to every byte, `LANES` bytes per clock. Its result leaves over a second valid/ready handshake. It is the decrypt-side counterpart of the forward S-box and sits in the inverse round datapath between InvShiftRows and AddRoundKey. The inverse S-box table is internal to the block, as a combinational per-lane lookup.

---
 rtl/aes_inv_sub_bytes.sv | 204 ++++++++++++++++++++
 tb/tb_aes_inv_sub_bytes.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_sub_bytes.sv
// ---------------------------------------------------------------------------
// aes_inv_sub_bytes
//
// Iterative AES InvSubBytes engine. A 128-bit state is accepted over a
// valid/ready handshake and every byte is replaced by its inverse S-box value.
// LANES bytes are processed per clock. The result is offered over a second
// valid/ready handshake.
//
// Parameters:
//   LANES      bytes substituted per cycle (1, 2, 4, 8 or 16)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data valid
//   in_ready   engine idle and able to take a state
//   in_data    input state, byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  out_data holds a complete result
//   out_ready  downstream accepts the result
//   out_data   substituted state, same byte order as in_data
//   busy       high while a state is being processed or held
//   chk_err    sticky self-check error
//
// Optional feature macro: AES_INV_SUB_BYTES_CHECK_EN
//   When defined, each lane also carries a forward S-box that recomputes
//   Sbox(InvSbox(b)) and compares it with b; any mismatch sets chk_err until
//   reset. When undefined, chk_err is tied low.
// ---------------------------------------------------------------------------
module aes_inv_sub_bytes #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         chk_err
);

    localparam int CHUNKS = 16 / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end

    // FIPS-197 inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[8 * (255 - int'(b)) +: 8];
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [127:0]    st;
    logic [127:0]    st_next;
    logic [127:0]    st_subst;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [3:0]      lane_idx [LANES];
    logic [7:0]      lane_in  [LANES];
    logic [8*LANES-1:0] inv_bytes;

    // Lane l works on byte cnt*LANES+l of the working register.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = 4'(int'(cnt) * LANES + l);
        assign lane_in[l]  = st[8 * (15 - int'(lane_idx[l])) +: 8];
        assign inv_bytes[8*l +: 8] = inv_sbox(lane_in[l]);
    end

    // Only the bytes of the current chunk take a lane result; byte k is served
    // by lane k % LANES when its chunk k / LANES is the active one.
    always_comb begin
        st_subst = st;
        for (int k = 0; k < 16; k++) begin
            if (k / LANES == int'(cnt)) begin
                st_subst[8 * (15 - k) +: 8] = inv_bytes[8 * (k % LANES) +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            st    <= st_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        st_next    = st;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    st_next    = in_data;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                st_next  = st_subst;
                cnt_next = cnt + CW'(1);
                if (cnt == CW'(CHUNKS - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = st;

`ifdef AES_INV_SUB_BYTES_CHECK_EN
    // FIPS-197 forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        return SBOX_TBL[8 * (255 - int'(b)) +: 8];
    endfunction

    logic chk_mis;
    logic chk_err_q;

    // Round-trip each lane through the forward box; any lane that does not
    // return its own input flags a fault in the inverse path.
    always_comb begin
        chk_mis = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (fwd_sbox(inv_bytes[8*l +: 8]) != lane_in[l]) begin
                chk_mis = 1'b1;
            end
        end
    end

    // Lanes only carry meaningful data in RUN, so the comparison is gated there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err_q <= 1'b0;
        end else if (state == RUN && chk_mis) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_sub_bytes
//
// Self-checking bench for aes_inv_sub_bytes. Instance 0 uses LANES=4 and runs
// the directed handshake, back-pressure and reset scenarios; instances 1..4
// use LANES=1, 2, 8 and 16 and sweep all 256 byte values. Expected results
// are queued when a state is accepted and a monitor compares data and latency
// whenever a DUT hands a result over.
// ---------------------------------------------------------------------------
module tb_aes_inv_sub_bytes;

    localparam int NI = 5;

    // Forward S-box; the bench derives its inverse model by inverting it.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        int           inst;
        logic [127:0] data;
        int           acc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [NI-1:0] in_valid_v;
    logic [127:0]  in_data;
    logic          out_ready;
    wire  [NI-1:0] in_ready_v;
    wire  [NI-1:0] out_valid_v;
    wire  [NI-1:0] busy_v;
    wire  [NI-1:0] chk_err_v;
    wire  [127:0]  out_data_v [NI];

    exp_t          sb[$];
    int            checks;
    int            errors;
    int            cycle;
    logic [7:0]    inv_model [256];
    logic [NI-1:0] prev_valid;
    int            rise [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
        aes_inv_sub_bytes #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .out_data  (out_data_v[g]),
            .busy      (busy_v[g]),
            .chk_err   (chk_err_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic int lat(input int i);
        case (i)
            0: return 4;
            1: return 16;
            2: return 8;
            3: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*(15-k) +: 8] = inv_model[d[8*(15-k) +: 8]];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one state into instance inst and queues its expected result.
    task automatic applyStimulus(input int inst, input logic [127:0] d,
                                 input logic [127:0] exp, input bit push);
        int n;
        @(posedge clk);
        #1;
        in_data          = d;
        in_valid_v[inst] = 1'b1;
        n = 0;
        while (!in_ready_v[inst] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready_v[inst]) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout inst %0d: in_ready got 0 expected 1", inst);
        end
        @(posedge clk);
        #1;
        in_valid_v[inst] = 1'b0;
        if (push) sb.push_back('{inst, exp, cycle});
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_pending", 128'(sb.size()), 128'd0);
    endtask

    // Monitor: pops one expectation per completed output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = '0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (out_valid_v[i] && !prev_valid[i]) rise[i] = cycle;
                if (out_valid_v[i] && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output inst %0d: got %h expected none", i, out_data_v[i]);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("result_inst", 128'(i), 128'(e.inst));
                        checkOutput("result_data", out_data_v[i], e.data);
                        checkOutput("result_latency", 128'(rise[i] - e.acc), 128'(lat(i)));
                    end
                end
            end
            prev_valid = out_valid_v;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] d;
        logic [127:0] exp;
        checks     = 0;
        errors     = 0;
        cycle      = 0;
        prev_valid = '0;
        for (int i = 0; i < NI; i++) rise[i] = 0;
        for (int x = 0; x < 256; x++) inv_model[SBOX_TBL[8*(255-x) +: 8]] = 8'(x);

        rst        = 1'b1;
        in_valid_v = '0;
        in_data    = '0;
        out_ready  = 1'b1;
        #1;
        checkOutput("reset_in_ready",  128'(in_ready_v[0]), 128'd1);
        checkOutput("reset_out_valid", 128'(out_valid_v[0]), 128'd0);
        checkOutput("reset_out_data",  out_data_v[0], 128'd0);
        checkOutput("reset_busy",      128'(busy_v[0]), 128'd0);
        checkOutput("reset_chk_err",   128'(chk_err_v), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed vectors, LANES=4");
        applyStimulus(0, {16{8'h63}}, {16{8'h00}}, 1'b1);
        applyStimulus(0, {32'h00010203, {12{8'h16}}}, {32'h52096ad5, {12{8'hff}}}, 1'b1);
        waitDrain();

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        applyStimulus(0, {16{8'h52}}, {16{8'h48}}, 1'b1);
        for (int n = 0; n < 20 && !out_valid_v[0]; n++) begin
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin
                in_data       = {16{8'h63}};
                in_valid_v[0] = 1'b1;
            end
            if (c == 6) in_valid_v[0] = 1'b0;
            @(negedge clk);
            checkOutput("hold_out_valid", 128'(out_valid_v[0]), 128'd1);
            checkOutput("hold_out_data",  out_data_v[0], {16{8'h48}});
            checkOutput("hold_in_ready",  128'(in_ready_v[0]), 128'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready",  128'(in_ready_v[0]), 128'd1);
        checkOutput("release_out_valid", 128'(out_valid_v[0]), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ignored_input_busy", 128'(busy_v[0]), 128'd0);
        waitDrain();

        $display("[TB] reset during RUN");
        applyStimulus(0, {16{8'hab}}, '0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready",  128'(in_ready_v[0]), 128'd1);
        checkOutput("midrst_out_valid", 128'(out_valid_v[0]), 128'd0);
        checkOutput("midrst_out_data",  out_data_v[0], 128'd0);
        checkOutput("midrst_busy",      128'(busy_v[0]), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        applyStimulus(0, {16{8'hed}}, {16{8'h53}}, 1'b1);
        waitDrain();

        $display("[TB] full byte sweep, LANES=1,2,8,16");
        for (int i = 1; i < NI; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int k = 0; k < 16; k++) d[8*(15-k) +: 8] = 8'(16*j + k);
                applyStimulus(i, d, model(d), 1'b1);
            end
            waitDrain();
        end

`ifdef AES_INV_SUB_BYTES_CHECK_EN
        $display("[TB] self-check lanes");
        for (int r = 0; r < 8; r++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(0, d, model(d), 1'b1);
        end
        waitDrain();
        checkOutput("chk_err_clean", 128'(chk_err_v), 128'd0);
        exp = {8'h01, {15{8'h00}}};
        applyStimulus(0, {16{8'h63}}, exp, 1'b1);
        force g_dut[0].u_dut.inv_bytes[0] = 1'b1;
        @(posedge clk);
        #1;
        release g_dut[0].u_dut.inv_bytes[0];
        checkOutput("chk_err_set", 128'(chk_err_v[0]), 128'd1);
        waitDrain();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("chk_err_sticky", 128'(chk_err_v[0]), 128'd1);
        rst = 1'b1;
        #1;
        checkOutput("chk_err_cleared", 128'(chk_err_v[0]), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`else
        exp = '0;
        checkOutput("chk_err_tied_low", 128'(chk_err_v), exp);
`endif

        repeat (2) @(posedge clk);
        #1;
        checkOutput("final_idle", 128'(in_ready_v), 128'({NI{1'b1}}));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
